mac_operand_feeder: RTL and testbench

Sequencer that drives a `mac` instance from the initiator side. On a start command it streams two operand vectors out of synchronous read memories into the MAC and frames the sum with `initialize`/`enable`. It then waits out the MAC pipeline, captures the accumulated dot product and offers it on a valid/ready output. It is the control front end for every dot-product / matmul row in the integer datapath.

---
 rtl/mac_operand_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_mac_operand_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// -----------------------------------------------------------------------------
// mac_operand_feeder
//
// Initiator-side sequencer for a MAC unit. A start command streams two operand
// vectors out of synchronous-read memories into the MAC, framing the sum with
// mac_initialize/mac_enable. It then waits out the MAC pipeline, captures the
// accumulated dot product and offers it on a valid/ready output.
//
// Ports
//   clk_i, rst_ni               clock (rising edge), async active-low reset
//   start_i, len_i              command strobe and vector length (0..2^ADDR_W)
//   base_a_i, base_b_i          operand start addresses, sampled with start_i
//   busy_o                      command in flight (through output handshake)
//   rd_en_o, rd_addr_a/b_o      memory read strobe and addresses
//   rd_data_a/b_i               read data, valid the cycle after rd_en_o
//   mac_enable_o, mac_initialize_o, mac_a_o, mac_b_o   MAC controls/operands
//   mac_result_i                MAC accumulator output
//   out_valid_o, out_ready_i, out_data_o   dot-product result handshake
// -----------------------------------------------------------------------------
module mac_operand_feeder #(
    parameter int D_W     = 32,
    parameter int D_W_ACC = 32,
    parameter int ADDR_W  = 10,
    parameter int MAC_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ADDR_W:0]           len_i,
    input  logic [ADDR_W-1:0]         base_a_i,
    input  logic [ADDR_W-1:0]         base_b_i,
    output logic                      busy_o,
    output logic                      rd_en_o,
    output logic [ADDR_W-1:0]         rd_addr_a_o,
    output logic [ADDR_W-1:0]         rd_addr_b_o,
    input  logic signed [D_W-1:0]     rd_data_a_i,
    input  logic signed [D_W-1:0]     rd_data_b_i,
    output logic                      mac_enable_o,
    output logic                      mac_initialize_o,
    output logic signed [D_W-1:0]     mac_a_o,
    output logic signed [D_W-1:0]     mac_b_o,
    input  logic signed [D_W_ACC-1:0] mac_result_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic signed [D_W_ACC-1:0] out_data_o
);

    // Drain counter must reach MAC_LAT; one spare bit keeps the compare safe.
    localparam int CNT_W = $clog2(MAC_LAT + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      rd_en_q, rd_en_d;
    logic                      mac_en_q, mac_en_d;
    logic                      mac_init_q, mac_init_d;
    logic                      first_q, first_d;
    logic                      out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]         addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]         addr_b_q, addr_b_d;
    logic [ADDR_W:0]           remain_q, remain_d;
    logic [CNT_W-1:0]          drain_q, drain_d;
    logic signed [D_W_ACC-1:0] out_data_q, out_data_d;

    // State and output registers; reset discards any command in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_init_q  <= 1'b0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            addr_a_q    <= {ADDR_W{1'b0}};
            addr_b_q    <= {ADDR_W{1'b0}};
            remain_q    <= {(ADDR_W + 1){1'b0}};
            drain_q     <= {CNT_W{1'b0}};
            out_data_q  <= {D_W_ACC{1'b0}};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            mac_en_q    <= mac_en_d;
            mac_init_q  <= mac_init_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            remain_q    <= remain_d;
            drain_q     <= drain_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state logic for the IDLE/READ/DRAIN/OUTPUT sequencer.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rd_en_d     = rd_en_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        remain_d    = remain_q;
        drain_d     = drain_q;
        out_data_d  = out_data_q;
        // mac_enable trails the read strobe by the memory read latency; the
        // first read of a command marks element 0, which restarts the sum.
        mac_en_d    = rd_en_q;
        mac_init_d  = rd_en_q & first_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    busy_d = 1'b1;
                    if (len_i == {(ADDR_W + 1){1'b0}}) begin
                        // Empty vector: answer zero without touching the MAC,
                        // whose accumulator still holds the previous sum.
                        out_valid_d = 1'b1;
                        out_data_d  = {D_W_ACC{1'b0}};
                        state_d     = ST_OUTPUT;
                    end else begin
                        rd_en_d  = 1'b1;
                        addr_a_d = base_a_i;
                        addr_b_d = base_b_i;
                        remain_d = len_i;
                        first_d  = 1'b1;
                        state_d  = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_READ: begin
                first_d = 1'b0;
                if (remain_q == (ADDR_W + 1)'(1)) begin
                    rd_en_d = 1'b0;
                    drain_d = {CNT_W{1'b0}};
                    state_d = ST_DRAIN;
                end else begin
                    remain_d = remain_q - (ADDR_W + 1)'(1);
                    // Natural ADDR_W-bit overflow gives the modulo wrap.
                    addr_a_d = addr_a_q + ADDR_W'(1);
                    addr_b_d = addr_b_q + ADDR_W'(1);
                end
            end

            ST_DRAIN: begin
                // One cycle for the final mac_enable, then MAC_LAT cycles of
                // MAC pipeline before the result is final.
                if (drain_q == CNT_W'(MAC_LAT)) begin
                    out_data_d  = mac_result_i;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUTPUT;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end

            ST_OUTPUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                rd_en_d     = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign busy_o           = busy_q;
    assign rd_en_o          = rd_en_q;
    assign rd_addr_a_o      = addr_a_q;
    assign rd_addr_b_o      = addr_b_q;
    assign mac_enable_o     = mac_en_q;
    assign mac_initialize_o = mac_init_q;
    assign out_valid_o      = out_valid_q;
    assign out_data_o       = out_data_q;

    // Operands pass straight through from memory, gated so they read zero
    // whenever the MAC is not consuming them (including under reset).
    assign mac_a_o = mac_en_q ? rd_data_a_i : {D_W{1'b0}};
    assign mac_b_o = mac_en_q ? rd_data_b_i : {D_W{1'b0}};

endmodule

// File: tb/tb_mac_operand_feeder.sv
module tb_mac_operand_feeder;

    localparam int D_W     = 32;
    localparam int D_W_ACC = 32;
    localparam int ADDR_W  = 10;
    localparam int MAC_LAT = 1;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int NV      = 6;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic                      start_i;
    logic [ADDR_W:0]           len_i;
    logic [ADDR_W-1:0]         base_a_i, base_b_i;
    logic                      busy_o, rd_en_o;
    logic [ADDR_W-1:0]         rd_addr_a_o, rd_addr_b_o;
    logic signed [D_W-1:0]     rd_data_a_i, rd_data_b_i;
    logic                      mac_enable_o, mac_initialize_o;
    logic signed [D_W-1:0]     mac_a_o, mac_b_o;
    logic signed [D_W_ACC-1:0] mac_result_i;
    logic                      out_valid_o, out_ready_i;
    logic signed [D_W_ACC-1:0] out_data_o;

    mac_operand_feeder #(
        .D_W(D_W), .D_W_ACC(D_W_ACC), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .base_a_i(base_a_i), .base_b_i(base_b_i), .busy_o(busy_o),
        .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
        .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
        .mac_enable_o(mac_enable_o), .mac_initialize_o(mac_initialize_o),
        .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_result_i(mac_result_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read operand memories.
    logic signed [D_W-1:0] mem_a [DEPTH];
    logic signed [D_W-1:0] mem_b [DEPTH];
    always @(posedge clk_i) begin
        if (rd_en_o) begin
            rd_data_a_i <= mem_a[rd_addr_a_o];
            rd_data_b_i <= mem_b[rd_addr_b_o];
        end
    end

    // Single-stage MAC (latency 1).
    logic signed [D_W_ACC-1:0] acc = '0;
    always @(posedge clk_i) begin
        if (mac_enable_o)
            acc <= mac_initialize_o ? (mac_a_o * mac_b_o) : (acc + mac_a_o * mac_b_o);
    end
    assign mac_result_i = acc;

    typedef struct packed {
        logic [31:0] len;
        logic [31:0] base_a;
        logic [31:0] base_b;
        logic [31:0] exp_sum;
        logic [31:0] exp_vcyc;
    } vec_t;

    vec_t vecs [NV];
    int   op_a [NV][8];
    int   op_b [NV][8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int l, input int ba, input int bb,
                           input int s, input int vc);
        vecs[i] = '{len: l, base_a: ba, base_b: bb, exp_sum: s, exp_vcyc: vc};
    endtask

    task automatic load_mem(input int i);
        for (int k = 0; k < int'(vecs[i].len); k++) begin
            mem_a[(int'(vecs[i].base_a) + k) % DEPTH] = op_a[i][k];
            mem_b[(int'(vecs[i].base_b) + k) % DEPTH] = op_b[i][k];
        end
    endtask

    // Runs one command starting at the next falling edge (cycle 0), with
    // out_ready held high; returns at the falling edge of the handshake cycle.
    task automatic run_cmd(input int i);
        int  cyc, n_rd, n_en, n_init, init_cyc, en_first, bad_addr, bad_op, vcyc;
        int  l, ba, bb;
        logic done;
        l = int'(vecs[i].len); ba = int'(vecs[i].base_a); bb = int'(vecs[i].base_b);
        cyc = 0; n_rd = 0; n_en = 0; n_init = 0; init_cyc = -1; en_first = -1;
        bad_addr = 0; bad_op = 0; vcyc = -1; done = 1'b0;
        @(negedge clk_i);
        check($sformatf("v%0d busy before start", i), busy_o, 0);
        check($sformatf("v%0d out_valid before start", i), out_valid_o, 0);
        load_mem(i);
        start_i = 1'b1; len_i = (ADDR_W + 1)'(l);
        base_a_i = ADDR_W'(ba); base_b_i = ADDR_W'(bb);
        while (!done && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
            start_i = 1'b0;
            if (rd_en_o) begin
                if (int'(rd_addr_a_o) != (ba + n_rd) % DEPTH) bad_addr++;
                if (int'(rd_addr_b_o) != (bb + n_rd) % DEPTH) bad_addr++;
                n_rd++;
            end
            if (mac_enable_o) begin
                if (n_en == 0) en_first = cyc;
                if (n_en < 8) begin
                    if (mac_a_o !== op_a[i][n_en]) bad_op++;
                    if (mac_b_o !== op_b[i][n_en]) bad_op++;
                end
                n_en++;
            end
            if (mac_initialize_o) begin
                n_init++;
                init_cyc = cyc;
            end
            if (out_valid_o) begin
                vcyc = cyc;
                done = 1'b1;
                check($sformatf("v%0d out_data", i), out_data_o, longint'($signed(vecs[i].exp_sum)));
                check($sformatf("v%0d busy at handshake", i), busy_o, 1);
            end
        end
        check($sformatf("v%0d completed in budget", i), done, 1);
        check($sformatf("v%0d out_valid cycle", i), vcyc, vecs[i].exp_vcyc);
        check($sformatf("v%0d rd_en count", i), n_rd, l);
        check($sformatf("v%0d mac_enable count", i), n_en, l);
        check($sformatf("v%0d mac_init count", i), n_init, (l > 0) ? 1 : 0);
        check($sformatf("v%0d mac_init cycle", i), init_cyc, (l > 0) ? 2 : -1);
        check($sformatf("v%0d mac_enable first cycle", i), en_first, (l > 0) ? 2 : -1);
        check($sformatf("v%0d address errors", i), bad_addr, 0);
        check($sformatf("v%0d operand errors", i), bad_op, 0);
    endtask

    initial begin
        int seen, vcnt;
        set_vec(0, 4,    0,  100,  70, 7);
        op_a[0] = '{1, 2, 3, 4, 0, 0, 0, 0};       op_b[0] = '{5, 6, 7, 8, 0, 0, 0, 0};
        set_vec(1, 2,   10,   20,  12, 5);
        op_a[1] = '{2, 2, 0, 0, 0, 0, 0, 0};       op_b[1] = '{3, 3, 0, 0, 0, 0, 0, 0};
        set_vec(2, 0,    5,    6,   0, 1);
        op_a[2] = '{0, 0, 0, 0, 0, 0, 0, 0};       op_b[2] = '{0, 0, 0, 0, 0, 0, 0, 0};
        set_vec(3, 1,   30,   40, -21, 4);
        op_a[3] = '{-3, 0, 0, 0, 0, 0, 0, 0};      op_b[3] = '{7, 0, 0, 0, 0, 0, 0, 0};
        set_vec(4, 4, 1022, 1021,  20, 7);
        op_a[4] = '{10, 20, 30, 40, 0, 0, 0, 0};   op_b[4] = '{1, 1, 1, -1, 0, 0, 0, 0};
        set_vec(5, 3,  500,  501, -32, 6);
        op_a[5] = '{-1, 2, -3, 0, 0, 0, 0, 0};     op_b[5] = '{4, -5, 6, 0, 0, 0, 0, 0};

        // Reset state.
        rst_ni = 1'b0; start_i = 1'b0; len_i = '0; base_a_i = '0; base_b_i = '0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("reset busy", busy_o, 0);
        check("reset rd_en", rd_en_o, 0);
        check("reset mac_enable", mac_enable_o, 0);
        check("reset mac_initialize", mac_initialize_o, 0);
        check("reset out_valid", out_valid_o, 0);
        check("reset rd_addr_a", rd_addr_a_o, 0);
        check("reset rd_addr_b", rd_addr_b_o, 0);
        check("reset mac_a", mac_a_o, 0);
        check("reset out_data", out_data_o, 0);
        rst_ni = 1'b1;

        // Table vectors, issued back to back at the minimum command period.
        for (int i = 0; i < NV; i++) run_cmd(i);

        // Backpressure: hold out_ready low for 5 cycles, pulse start mid-stall.
        @(negedge clk_i);
        load_mem(1);
        out_ready_i = 1'b0;
        start_i = 1'b1; len_i = 11'd2; base_a_i = 10'd10; base_b_i = 10'd20;
        vcnt = 0;
        @(negedge clk_i);
        start_i = 1'b0;
        while (!out_valid_o && vcnt < 50) begin
            @(negedge clk_i);
            vcnt++;
        end
        check("stall out_valid reached", out_valid_o, 1);
        for (int s = 0; s < 5; s++) begin
            check($sformatf("stall%0d out_valid", s), out_valid_o, 1);
            check($sformatf("stall%0d out_data", s), out_data_o, 12);
            check($sformatf("stall%0d busy", s), busy_o, 1);
            if (s == 1) begin
                start_i = 1'b1; len_i = 11'd3; base_a_i = 10'd500; base_b_i = 10'd501;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        check("stall end out_data", out_data_o, 12);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (rd_en_o || busy_o || out_valid_o) seen++;
        end
        check("stall start not queued", seen, 0);

        // Reset in cycle 3 of an L=8 command.
        @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
            mem_a[200 + k] = k + 1;
            mem_b[300 + k] = 2;
        end
        start_i = 1'b1; len_i = 11'd8; base_a_i = 10'd200; base_b_i = 10'd300;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("pre-reset rd_en", rd_en_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid reset busy", busy_o, 0);
        check("mid reset rd_en", rd_en_o, 0);
        check("mid reset mac_enable", mac_enable_o, 0);
        check("mid reset mac_initialize", mac_initialize_o, 0);
        check("mid reset out_valid", out_valid_o, 0);
        check("mid reset rd_addr_a", rd_addr_a_o, 0);
        check("mid reset rd_addr_b", rd_addr_b_o, 0);
        check("mid reset mac_a", mac_a_o, 0);
        check("mid reset out_data", out_data_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_i);
            if (out_valid_o || rd_en_o || busy_o) seen++;
        end
        check("no activity after reset", seen, 0);
        run_cmd(0);
        run_cmd(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
